// File: rtl/grslatch_arbiter.sv
// grslatch_arbiter: round-robin sequencer driving shared R/S and one-hot ENA into a gated RS latch bank
module grslatch_arbiter #(
    parameter int NLATCH    = 8,
    parameter int AW        = 3,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ0,
    input  logic [AW-1:0]     ADDR0,
    input  logic              VAL0,
    output logic              ACK0,
    input  logic              REQ1,
    input  logic [AW-1:0]     ADDR1,
    input  logic              VAL1,
    output logic              ACK1,
    output logic [NLATCH-1:0] ENA,
    output logic              R,
    output logic              S,
    output logic              BUSY,
    output logic              GNT
);
    localparam int CW = $clog2((PULSE_CYC > HOLD_CYC ? PULSE_CYC : HOLD_CYC) + 1);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [AW-1:0] addr;
    logic          ptr, win, grant, val, val_n, rs_on;

    // Next state, arbitration winner and next captured value; outputs are decoded from the next state so they stay registered
    always_comb begin
        grant   = state == IDLE && (REQ0 || REQ1);
        win     = (REQ0 && REQ1) ? ptr : REQ1;
        val_n   = grant ? (win ? VAL1 : VAL0) : val;
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE:  state_n = grant ? SETUP : IDLE;
            SETUP: begin
                state_n = PULSE;
                cnt_n   = CW'(PULSE_CYC - 1);
            end
            PULSE: begin
                state_n = cnt == '0 ? HOLD : PULSE;
                cnt_n   = cnt == '0 ? CW'(HOLD_CYC - 1) : cnt - CW'(1);
            end
            HOLD: begin
                state_n = cnt == '0 ? DONE : HOLD;
                cnt_n   = cnt == '0 ? cnt : cnt - CW'(1);
            end
            default: state_n = IDLE;
        endcase
        rs_on = state_n == SETUP || state_n == PULSE || state_n == HOLD;
    end

    // State, grant capture and registered bank outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= 1'b0;
            addr  <= '0;
            val   <= 1'b0;
            GNT   <= 1'b0;
            ENA   <= '0;
            R     <= 1'b0;
            S     <= 1'b0;
            ACK0  <= 1'b0;
            ACK1  <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            val   <= val_n;
            if (grant) begin
                GNT  <= win;
                ptr  <= ~win;
                addr <= win ? ADDR1 : ADDR0;
            end
            ENA  <= (state_n == PULSE && 32'(addr) < NLATCH) ? NLATCH'(1) << addr : '0;
            R    <= rs_on & ~val_n;
            S    <= rs_on & val_n;
            ACK0 <= state_n == DONE && !GNT;
            ACK1 <= state_n == DONE && GNT;
            BUSY <= state_n != IDLE;
        end
    end
endmodule
